spi_cmd_ctrl: RTL and testbench

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_if.sv | 26 ++
 rtl/spi_cmd_ctrl.sv | 116 +++++++++++
 tb/tb_spi_cmd_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_if.sv
// Register-access bundle between the SPI byte bridge, the command
// controller and the register file.
interface spi_cmd_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic              read;
    logic [7:0]        data_write;
    logic [7:0]        data_read;
    logic              frame_err;

    modport slave (
        input  cs_n, byte_sync, data_in, data_read,
        output data_out, addr, write, read, data_write, frame_err
    );

    modport master (
        output cs_n, byte_sync, data_in, data_read,
        input  data_out, addr, write, read, data_write, frame_err
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: turns bridge bytes into register read/write
// strobes with burst auto-increment and aborted-frame detection.
module spi_cmd_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_cmd_if.slave  bus
);
    typedef enum logic [1:0] {
        S_CMD,
        S_WDATA,
        S_RDATA
    } state_t;

    state_t            state;
    logic [2:0]        bs_q;
    logic [2:0]        cs_q;
    logic              ev;
    logic              cs_rise;
    logic              burst;
    logic              got_data;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dout_q;
    logic [7:0]        dw_q;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;

    // Edges are registered once more so strobes land 3 clk after first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bs_q    <= 3'b000;
            cs_q    <= 3'b111;
            ev      <= 1'b0;
            cs_rise <= 1'b0;
        end else begin
            bs_q    <= {bs_q[1:0], bus.byte_sync};
            cs_q    <= {cs_q[1:0], bus.cs_n};
            ev      <= bs_q[1] & ~bs_q[2];
            cs_rise <= cs_q[1] & ~cs_q[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CMD;
            burst    <= 1'b0;
            got_data <= 1'b0;
            addr_q   <= '0;
            dout_q   <= 8'h00;
            dw_q     <= 8'h00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            if (wr_q && burst)
                addr_q <= addr_q + ADDR_W'(1);
            if (rd_q && state == S_RDATA)
                dout_q <= bus.data_read;
            unique case (state)
                S_CMD: begin
                    if (ev) begin
                        addr_q   <= bus.data_in[ADDR_W-1:0];
                        burst    <= bus.data_in[6];
                        got_data <= 1'b0;
                        if (bus.data_in[7]) begin
                            state <= S_WDATA;
                        end else begin
                            rd_q  <= 1'b1;
                            state <= S_RDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (ev) begin
                        wr_q     <= 1'b1;
                        dw_q     <= bus.data_in;
                        got_data <= 1'b1;
                        if (!burst)
                            state <= S_CMD;
                    end
                end
                S_RDATA: begin
                    if (ev) begin
                        if (burst) begin
                            addr_q <= addr_q + ADDR_W'(1);
                            rd_q   <= 1'b1;
                        end else begin
                            state  <= S_CMD;
                            dout_q <= 8'h00;
                        end
                    end
                end
                default: state <= S_CMD;
            endcase
            // A byte in the same clk as cs rise counts as received data.
            if (cs_rise) begin
                state  <= S_CMD;
                dout_q <= 8'h00;
                if (state == S_WDATA && !got_data && !ev)
                    err_q <= 1'b1;
            end
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.addr       = addr_q;
    assign bus.write      = wr_q;
    assign bus.read       = rd_q;
    assign bus.data_write = dw_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: frame-level strobe model plus
// per-cycle output compare and literal spot checks.
module tb_spi_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_cmd_if #(.ADDR_W(6)) bus ();
    spi_cmd_ctrl #(.ADDR_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [1:0] k;
        logic [5:0] a;
        logic [7:0] d;
    } ev_t;
    typedef struct packed {
        int  cyc;
        ev_t e;
    } exp_t;

    localparam logic [1:0] K_W = 2'd1;
    localparam logic [1:0] K_R = 2'd2;
    localparam logic [1:0] K_E = 2'd3;

    exp_t       expq[$];
    ev_t        log_q[$];
    logic [7:0] dlog[$];
    logic [7:0] regs [64];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always_comb bus.data_read = regs[bus.addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Strobes become visible 4 negedges after byte_sync/cs_n is driven.
    task automatic push(input logic [1:0] k, input logic [5:0] a, input logic [7:0] d);
        exp_t x;
        x.cyc = cyc + 4;
        x.e.k = k;
        x.e.a = a;
        x.e.d = d;
        expq.push_back(x);
    endtask

    logic       xw, xr, xe;
    logic [5:0] xa;
    logic [7:0] xd;
    always @(negedge clk) begin
        if (chk_on) begin
            xw = 1'b0; xr = 1'b0; xe = 1'b0; xa = '0; xd = '0;
            while (expq.size() != 0 && expq[0].cyc <= cyc) begin
                if (expq[0].cyc == cyc) begin
                    if (expq[0].e.k == K_W) begin
                        xw = 1'b1; xa = expq[0].e.a; xd = expq[0].e.d;
                    end else if (expq[0].e.k == K_R) begin
                        xr = 1'b1; xa = expq[0].e.a;
                    end else begin
                        xe = 1'b1;
                    end
                end
                void'(expq.pop_front());
            end
            chk("write", 32'(bus.write), 32'(xw));
            chk("read", 32'(bus.read), 32'(xr));
            chk("frame_err", 32'(bus.frame_err), 32'(xe));
            if (xw || xr) chk("addr", 32'(bus.addr), 32'(xa));
            if (xw) chk("data_write", 32'(bus.data_write), 32'(xd));
            if (bus.write === 1'b1) log_q.push_back({K_W, bus.addr, bus.data_write});
            if (bus.read === 1'b1) log_q.push_back({K_R, bus.addr, 8'h00});
            if (bus.frame_err === 1'b1) log_q.push_back({K_E, 6'd0, 8'h00});
        end
    end

    task automatic dout_chk(input logic [7:0] x);
        chk("data_out", 32'(bus.data_out), 32'(x));
        dlog.push_back(bus.data_out);
    endtask

    task automatic send(input logic [7:0] b, input bit cs_hi, input bit has,
                        input logic [1:0] k, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.data_in = b;
        bus.byte_sync = 1'b1;
        if (cs_hi) bus.cs_n = 1'b1;
        if (has) push(k, a, d);
        repeat (3) @(negedge clk);
        bus.byte_sync = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2, input bit cs_last);
        logic [7:0] db [3];
        logic [5:0] a;
        logic [7:0] xo;
        bit wr, bst;
        db[0] = d0; db[1] = d1; db[2] = d2;
        a = cmd[5:0]; wr = cmd[7]; bst = cmd[6];
        log_q.delete();
        dlog.delete();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (3) @(negedge clk);
        dout_chk(8'h00);
        send(cmd, cs_last && n == 0, !wr, K_R, a, 8'h00);
        for (int i = 0; i < n; i++) begin
            xo = (!wr && (bst || i == 0)) ? regs[a + 6'(i)] : 8'h00;
            dout_chk(xo);
            if (wr)
                send(db[i], cs_last && i == n - 1, bst || i == 0, K_W, a + 6'(i), db[i]);
            else
                send(db[i], cs_last && i == n - 1, bst, K_R, a + 6'(i + 1), 8'h00);
        end
        if (!cs_last) begin
            xo = (!wr && (bst || n == 0)) ? regs[a + 6'(n)] : 8'h00;
            dout_chk(xo);
            bus.cs_n = 1'b1;
            if (wr && n == 0) push(K_E, 6'd0, 8'h00);
            repeat (8) @(negedge clk);
        end
        dout_chk(8'h00);
    endtask

    task automatic lit_ev(input string nm, input int idx, input logic [1:0] k,
                          input logic [5:0] a, input logic [7:0] d);
        if (idx < log_q.size())
            chk(nm, 32'(log_q[idx]), 32'({k, a, d}));
        else
            chk({nm, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
    endtask

    task automatic lit_dout(input string nm, input int idx, input logic [7:0] x);
        if (idx < dlog.size())
            chk(nm, 32'(dlog[idx]), 32'(x));
        else
            chk({nm, "_missing"}, 32'(dlog.size()), 32'(idx + 1));
    endtask

    task automatic reset_outs(input string nm);
        chk({nm, "_data_out"}, 32'(bus.data_out), 32'h0);
        chk({nm, "_addr"}, 32'(bus.addr), 32'h0);
        chk({nm, "_write"}, 32'(bus.write), 32'h0);
        chk({nm, "_read"}, 32'(bus.read), 32'h0);
        chk({nm, "_data_write"}, 32'(bus.data_write), 32'h0);
        chk({nm, "_frame_err"}, 32'(bus.frame_err), 32'h0);
    endtask

    initial begin
        bus.cs_n = 1'b1;
        bus.byte_sync = 1'b0;
        bus.data_in = 8'h00;
        for (int i = 0; i < 64; i++) regs[i] = 8'(8'h20 + i * 5);
        regs[3] = 8'h3C;
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        reset_outs("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        frame(8'h85, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
        chk("wr1_count", 32'(log_q.size()), 32'd1);
        lit_ev("wr1_ev", 0, K_W, 6'd5, 8'hA5);

        frame(8'h03, 1, 8'h99, 8'h00, 8'h00, 1'b0);
        chk("rd1_count", 32'(log_q.size()), 32'd1);
        lit_ev("rd1_ev", 0, K_R, 6'd3, 8'h00);
        lit_dout("rd1_dout", 1, 8'h3C);
        lit_dout("rd1_dout_end", 2, 8'h00);

        frame(8'hFE, 3, 8'h11, 8'h22, 8'h33, 1'b0);
        chk("bw_count", 32'(log_q.size()), 32'd3);
        lit_ev("bw_ev0", 0, K_W, 6'd62, 8'h11);
        lit_ev("bw_ev1", 1, K_W, 6'd63, 8'h22);
        lit_ev("bw_ev2", 2, K_W, 6'd0, 8'h33);

        frame(8'h41, 2, 8'hF0, 8'hF1, 8'h00, 1'b0);
        chk("br_count", 32'(log_q.size()), 32'd3);
        lit_ev("br_ev0", 0, K_R, 6'd1, 8'h00);
        lit_ev("br_ev1", 1, K_R, 6'd2, 8'h00);
        lit_ev("br_ev2", 2, K_R, 6'd3, 8'h00);
        lit_dout("br_dout0", 1, 8'h25);
        lit_dout("br_dout1", 2, 8'h2A);
        lit_dout("br_dout2", 3, 8'h3C);

        frame(8'h80, 0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("abort_count", 32'(log_q.size()), 32'd1);
        lit_ev("abort_ev", 0, K_E, 6'd0, 8'h00);
        frame(8'h8A, 1, 8'h5A, 8'h00, 8'h00, 1'b0);
        lit_ev("post_abort_ev", 0, K_W, 6'd10, 8'h5A);

        frame(8'h82, 1, 8'h77, 8'h00, 8'h00, 1'b1);
        chk("same_clk_count", 32'(log_q.size()), 32'd1);
        lit_ev("same_clk_ev", 0, K_W, 6'd2, 8'h77);

        log_q.delete();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (3) @(negedge clk);
        send(8'h80, 1'b0, 1'b0, K_W, 6'd0, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_outs("midrst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        dout_chk(8'h00);
        send(8'h07, 1'b0, 1'b1, K_R, 6'd7, 8'h00);
        dout_chk(regs[7]);
        chk("midrst_dout_lit", 32'(bus.data_out), 32'h43);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clk);
        dout_chk(8'h00);
        chk("midrst_count", 32'(log_q.size()), 32'd1);
        lit_ev("midrst_ev", 0, K_R, 6'd7, 8'h00);

        repeat (4) @(negedge clk);
        chk("expq_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
